imem_fetch_sequencer: RTL and testbench
=======================================

Name: imem_fetch_sequencer

Overview:
- Owns the PC and sequences the single read port of InstructionMemory (combinational, word-addressed on d[ADDR_W-1:2]).
- Shares that port between the IF stage and a debug/loader read requester.
- Applies freeze and branch redirects from the pipeline and registers the IF/ID outputs.
- Sits between InstructionMemory and the IF/ID register path.

Parameters:
- ADDR_W, `ADDRESS_LEN (32): address and instruction width.
- RESET_PC, 0: PC value loaded on reset.
- DBG_MAX_WAIT, 4: cycles a pending debug request waits before it is forced a grant. 0 means it is granted immediately.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- freeze  in  1  hazard stall; no fetch this cycle.
- branch_taken  in  1  redirect PC this cycle.
- branch_addr  in  ADDR_W  branch target; bits [1:0] ignored.
- mem_addr  out  ADDR_W  to InstructionMemory d; combinational, bits [1:0] always 0.
- mem_rdata  in  ADDR_W  from InstructionMemory q.
- if_pc  out  ADDR_W  PC+4 of the delivered instruction.
- if_instr  out  ADDR_W  delivered instruction.
- if_valid  out  1  if_instr is a real fetch.
- dbg_req  in  1  debug read request; level, held until dbg_gnt.
- dbg_addr  in  ADDR_W  debug read address; bits [1:0] ignored.
- dbg_gnt  out  1  combinational; the port serves debug this cycle.
- dbg_rdata  out  ADDR_W  registered debug read data.
- dbg_rvalid  out  1  one-cycle pulse, the cycle after dbg_gnt.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC, if_pc=0, if_instr=0, if_valid=0.
  - dbg_rdata=0, dbg_rvalid=0, wait_cnt=0, state=BOOT.
  - Reset mid-operation drops any pending or granted debug access; no rvalid follows.
- States:
  - BOOT: first cycle after reset release. No fetch, no grant, mem_addr=pc. Goes to RUN unconditionally.
  - RUN: normal operation.
- Port owner each RUN cycle:
  - dbg_gnt = dbg_req & (freeze | wait_cnt==DBG_MAX_WAIT).
  - mem_addr = dbg_gnt ? {dbg_addr[ADDR_W-1:2],2'b00} : pc.
- Fetch cycle (RUN, !freeze, !dbg_gnt, !branch_taken). At the clock edge:
  - if_instr<=mem_rdata, if_pc<=pc+4, if_valid<=1, pc<=pc+4.
  - pc+4 wraps modulo 2^ADDR_W.
- Branch (branch_taken=1, any RUN cycle, overrides freeze and debug):
  - pc<={branch_addr[ADDR_W-1:2],2'b00}, if_valid<=0, if_instr<=0.
  - Any debug access in that same cycle still completes.
- Freeze without branch: pc, if_pc, if_instr, if_valid hold.
- Debug steal (dbg_gnt=1, freeze=0, no branch): pc holds, if_valid<=0, if_instr/if_pc hold.
- Debug completion: edge after a dbg_gnt cycle sets dbg_rdata<=mem_rdata, dbg_rvalid<=1. Otherwise dbg_rvalid<=0.
- Starvation counter wait_cnt:
  - Increments (saturating at DBG_MAX_WAIT) when dbg_req & !dbg_gnt.
  - Clears on grant or when dbg_req=0.
- Latency:
  - Fetch: instruction on if_instr one cycle after its address is on mem_addr.
  - Debug read: 1 cycle after grant.
  - Debug worst-case wait without freeze: DBG_MAX_WAIT cycles.
- Throughput: at most one port access per cycle; fetch and debug are never both served in one cycle.

Optional Feature:
- Macro: IF_HALT_EN.
- Enabled: adds input halt_req and output halted, plus state HALT.
  - RUN->HALT at the edge where halt_req=1. That cycle behaves as freeze, and branch is still honoured.
  - In HALT: halted=1, no fetch, if_valid<=0, dbg_gnt=dbg_req every cycle, wait_cnt held at 0.
  - HALT->RUN when halt_req=0; fetch resumes from the held pc.
  - Reset value halted=0.
- Disabled: no halt_req/halted ports, no HALT state; behaviour exactly as above.

Test Plan:
- Reset then run with the standard InstructionMemory image, no freeze or debug:
  - BOOT cycle has if_valid=0.
  - Then if_instr=0xE3A00015/if_pc=4, 0xE3A01A01/8, 0xE3A0DC02/12 on consecutive cycles.
- Freeze held 3 cycles after the second fetch: if_instr stays 0xE3A01A01, if_valid stays 1 and pc stays 8; the third fetch resumes as 0xE3A0DC02/12.
- branch_taken with branch_addr=0x1E while freeze=1:
  - Next cycle if_valid=0, pc=0x1C.
  - Following cycle if_instr=0xEAFFFFFF, if_pc=0x20.
- dbg_req with dbg_addr=0x8 and freeze=0, DBG_MAX_WAIT=4:
  - dbg_gnt rises on the 5th request cycle.
  - Next cycle dbg_rvalid=1, dbg_rdata=0xE3A0DC02, if_valid=0 and pc unchanged.
- dbg_req during a freeze cycle: immediate grant, rvalid the next cycle, IF outputs unaffected.
- rst asserted in the cycle after dbg_gnt: dbg_rvalid stays 0, all outputs return to reset values asynchronously, and the BOOT cycle follows release.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// rtl/imem_fetch_sequencer.sv - PC owner and InstructionMemory port sequencer feeding IF/ID
// Optional halt support (halt_req/halted, HALT state) is built when IF_HALT_EN is defined.

`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

module imem_fetch_sequencer #(
  parameter int                ADDR_W       = `ADDRESS_LEN,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                DBG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_instr,
  output logic              if_valid,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic [ADDR_W-1:0] dbg_rdata,
  output logic              dbg_rvalid
`ifdef IF_HALT_EN
  ,
  input  logic              halt_req,
  output logic              halted
`endif
);

  localparam int             WCW      = (DBG_MAX_WAIT < 1) ? 1 : $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(DBG_MAX_WAIT);

  typedef enum logic [1:0] {
    BOOT,
`ifdef IF_HALT_EN
    HALT,
`endif
    RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] dbg_word;
  logic [WCW-1:0]    wait_cnt;
  logic              wait_max;
  logic              stall;
  logic              unused_low_bits;

  assign pc_plus4   = pc + ADDR_W'(4);
  assign branch_tgt = {branch_addr[ADDR_W-1:2], 2'b00};
  assign dbg_word   = {dbg_addr[ADDR_W-1:2], 2'b00};
  assign wait_max   = (wait_cnt == WAIT_MAX);
  assign unused_low_bits = ^{branch_addr[1:0], dbg_addr[1:0]};

  // A halt request makes its RUN cycle look like a freeze, so debug may take the port.
`ifdef IF_HALT_EN
  assign stall = freeze | halt_req;
`else
  assign stall = freeze;
`endif

  always_comb begin
    dbg_gnt  = 1'b0;
    mem_addr = pc;
    case (state)
      RUN:     dbg_gnt = dbg_req & (stall | wait_max);
`ifdef IF_HALT_EN
      HALT:    dbg_gnt = dbg_req;
`endif
      default: dbg_gnt = 1'b0;
    endcase
    if (dbg_gnt) begin
      mem_addr = dbg_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      pc         <= {RESET_PC[ADDR_W-1:2], 2'b00};
      if_pc      <= '0;
      if_instr   <= '0;
      if_valid   <= 1'b0;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
      wait_cnt   <= '0;
`ifdef IF_HALT_EN
      halted     <= 1'b0;
`endif
    end else begin
      dbg_rvalid <= dbg_gnt;
      if (dbg_gnt) begin
        dbg_rdata <= mem_rdata;
      end

      // Starvation counter: consecutive cycles a request has been refused.
      if (dbg_req && !dbg_gnt) begin
        if (!wait_max) begin
          wait_cnt <= wait_cnt + WCW'(1);
        end
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (branch_taken) begin
            pc       <= branch_tgt;
            if_valid <= 1'b0;
            if_instr <= '0;
          end else if (stall) begin
            pc <= pc;
          end else if (dbg_gnt) begin
            if_valid <= 1'b0;
          end else begin
            if_instr <= mem_rdata;
            if_pc    <= pc_plus4;
            if_valid <= 1'b1;
            pc       <= pc_plus4;
          end
`ifdef IF_HALT_EN
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end
`endif
        end
`ifdef IF_HALT_EN
        HALT: begin
          if_valid <= 1'b0;
          if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
`endif
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb/tb_imem_fetch_sequencer.sv - directed and randomized bench for imem_fetch_sequencer

module tb_imem_fetch_sequencer;

  localparam int DBGW = 4;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;

  logic [31:0] imem [64];
  int checks;
  int errors;

  imem_fetch_sequencer #(
    .ADDR_W      (32),
    .RESET_PC    (32'h0),
    .DBG_MAX_WAIT(DBGW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_gnt     (dbg_gnt),
    .dbg_rdata   (dbg_rdata),
    .dbg_rvalid  (dbg_rvalid)
  );

  assign mem_rdata = imem[mem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    dbg_req = 1'b1; dbg_addr = 32'h10;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got %h exp 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr got %h exp 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc got %h exp 0", if_pc); end
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dbg_rvalid got %h exp 0", dbg_rvalid); end
    checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL rst_dbg_rdata got %h exp 0", dbg_rdata); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL rst_dbg_gnt got %h exp 0", dbg_gnt); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    rst = 1'b1; freeze = 1'b1;
    #1;
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL boot_no_gnt got %h exp 0", dbg_gnt); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL boot_mem_addr got %h exp 0", mem_addr); end
  endtask

  task automatic test_fetch();
    step();
    dbg_req = 1'b0; freeze = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_if_valid got %h exp 0", if_valid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL run0_mem_addr got %h exp 0", mem_addr); end
    step();
    checks++; if (if_instr !== 32'hE3A00015 || if_pc !== 32'd4 || if_valid !== 1'b1) begin errors++; $display("FAIL fetch0 got %h/%h/%h exp e3a00015/4/1", if_instr, if_pc, if_valid); end
    step();
    checks++; if (if_instr !== 32'hE3A01A01 || if_pc !== 32'd8 || if_valid !== 1'b1) begin errors++; $display("FAIL fetch1 got %h/%h/%h exp e3a01a01/8/1", if_instr, if_pc, if_valid); end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (if_instr !== 32'hE3A01A01 || if_pc !== 32'd8 || if_valid !== 1'b1) begin errors++; $display("FAIL freeze_hold%0d got %h/%h/%h exp e3a01a01/8/1", i, if_instr, if_pc, if_valid); end
      checks++; if (mem_addr !== 32'd8) begin errors++; $display("FAIL freeze_pc%0d got %h exp 8", i, mem_addr); end
    end
    freeze = 1'b0;
    step();
    checks++; if (if_instr !== 32'hE3A0DC02 || if_pc !== 32'd12 || if_valid !== 1'b1) begin errors++; $display("FAIL fetch2 got %h/%h/%h exp e3a0dc02/c/1", if_instr, if_pc, if_valid); end
  endtask

  task automatic test_branch();
    freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h1E;
    step();
    freeze = 1'b0; branch_taken = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin errors++; $display("FAIL branch_flush got %h/%h exp 0/0", if_valid, if_instr); end
    checks++; if (mem_addr !== 32'h1C) begin errors++; $display("FAIL branch_pc got %h exp 1c", mem_addr); end
    step();
    checks++; if (if_instr !== 32'hEAFFFFFF || if_pc !== 32'h20 || if_valid !== 1'b1) begin errors++; $display("FAIL branch_fetch got %h/%h/%h exp eaffffff/20/1", if_instr, if_pc, if_valid); end
  endtask

  task automatic test_debug_starvation();
    logic [31:0] exp_addr;
    dbg_addr = 32'h8; dbg_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      exp_addr = (i == 5) ? 32'h8 : 32'h20 + 32'(4 * (i - 1));
      checks++; if (dbg_gnt !== (i == 5)) begin errors++; $display("FAIL starve_gnt%0d got %h exp %h", i, dbg_gnt, (i == 5)); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL starve_addr%0d got %h exp %h", i, mem_addr, exp_addr); end
      step();
    end
    dbg_req = 1'b0;
    #1;
    checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hE3A0DC02) begin errors++; $display("FAIL starve_rdata got %h/%h exp 1/e3a0dc02", dbg_rvalid, dbg_rdata); end
    checks++; if (if_valid !== 1'b0 || mem_addr !== 32'h30) begin errors++; $display("FAIL starve_steal got %h/%h exp 0/30", if_valid, mem_addr); end
    checks++; if (if_instr !== imem[11] || if_pc !== 32'h30) begin errors++; $display("FAIL starve_hold got %h/%h exp %h/30", if_instr, if_pc, imem[11]); end
    step();
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL starve_pulse got %h exp 0", dbg_rvalid); end
    checks++; if (if_instr !== imem[12] || if_pc !== 32'h34 || if_valid !== 1'b1) begin errors++; $display("FAIL starve_resume got %h/%h/%h exp %h/34/1", if_instr, if_pc, if_valid, imem[12]); end
  endtask

  task automatic test_debug_freeze();
    freeze = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h1F;
    #1;
    checks++; if (dbg_gnt !== 1'b1 || mem_addr !== 32'h1C) begin errors++; $display("FAIL frz_gnt got %h/%h exp 1/1c", dbg_gnt, mem_addr); end
    step();
    dbg_req = 1'b0; freeze = 1'b0;
    #1;
    checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hEAFFFFFF) begin errors++; $display("FAIL frz_rdata got %h/%h exp 1/eaffffff", dbg_rvalid, dbg_rdata); end
    checks++; if (if_valid !== 1'b1 || if_instr !== imem[12] || if_pc !== 32'h34 || mem_addr !== 32'h34) begin errors++; $display("FAIL frz_if_hold got %h/%h/%h/%h exp 1/%h/34/34", if_valid, if_instr, if_pc, mem_addr, imem[12]); end
    step();
    checks++; if (dbg_rvalid !== 1'b0 || if_instr !== imem[13] || if_pc !== 32'h38) begin errors++; $display("FAIL frz_after got %h/%h/%h exp 0/%h/38", dbg_rvalid, if_instr, if_pc, imem[13]); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin errors++; $display("FAIL wrap_branch got %h/%h exp fffffffc/0", mem_addr, if_valid); end
    step();
    checks++; if (if_pc !== 32'h0 || if_instr !== imem[63] || if_valid !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_fetch got %h/%h/%h/%h exp 0/%h/1/0", if_pc, if_instr, if_valid, mem_addr, imem[63]); end
  endtask

  task automatic test_reset_after_grant();
    freeze = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h4;
    #1;
    checks++; if (dbg_gnt !== 1'b1) begin errors++; $display("FAIL rg_gnt got %h exp 1", dbg_gnt); end
    rst = 1'b0;
    #1;
    checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0 || dbg_gnt !== 1'b0) begin errors++; $display("FAIL rg_async_dbg got %h/%h/%h exp 0/0/0", dbg_rvalid, dbg_rdata, dbg_gnt); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rg_async_if got %h/%h/%h/%h exp 0/0/0/0", if_valid, if_instr, if_pc, mem_addr); end
    step();
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rg_no_rvalid got %h exp 0", dbg_rvalid); end
    dbg_req = 1'b0; freeze = 1'b0; rst = 1'b1;
    step();
    checks++; if (if_valid !== 1'b0 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rg_boot got %h/%h exp 0/0", if_valid, dbg_rvalid); end
    step();
    checks++; if (if_instr !== 32'hE3A00015 || if_pc !== 32'd4) begin errors++; $display("FAIL rg_refetch got %h/%h exp e3a00015/4", if_instr, if_pc); end
  endtask

  task automatic test_random();
    logic [31:0] m_pc, m_ifpc, m_instr, m_rdata, e_addr;
    logic        m_valid, m_rvalid, m_boot, e_gnt, m_gnt_prev;
    int          m_wait;
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; dbg_req = 1'b0;
    step();
    rst = 1'b1;
    m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h0; m_rdata = 32'h0;
    m_valid = 1'b0; m_rvalid = 1'b0; m_boot = 1'b1; m_gnt_prev = 1'b0; m_wait = 0;
    for (int n = 0; n < 600; n++) begin
      freeze       = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      branch_addr  = $urandom_range(0, 255);
      if (!dbg_req || m_gnt_prev) begin
        dbg_req  = ($urandom_range(0, 2) == 0);
        dbg_addr = $urandom_range(0, 255);
      end
      #1;
      e_gnt  = !m_boot && dbg_req && (freeze || m_wait >= DBGW);
      e_addr = e_gnt ? (dbg_addr & ~32'h3) : m_pc;
      checks++; if (dbg_gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt n=%0d got %h exp %h", n, dbg_gnt, e_gnt); end
      checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr n=%0d got %h exp %h", n, mem_addr, e_addr); end
      m_rvalid = e_gnt;
      if (e_gnt) m_rdata = imem[(dbg_addr >> 2) % 64];
      m_wait = (dbg_req && !e_gnt) ? ((m_wait < DBGW) ? m_wait + 1 : DBGW) : 0;
      if (!m_boot) begin
        if (branch_taken) begin
          m_pc = branch_addr & ~32'h3; m_valid = 1'b0; m_instr = 32'h0;
        end else if (!freeze) begin
          if (e_gnt) begin
            m_valid = 1'b0;
          end else begin
            m_instr = imem[(m_pc >> 2) % 64];
            m_pc    = m_pc + 32'd4;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
          end
        end
      end
      m_boot = 1'b0;
      m_gnt_prev = e_gnt;
      step();
      checks++; if (if_valid !== m_valid || if_instr !== m_instr || if_pc !== m_ifpc) begin errors++; $display("FAIL rnd_if n=%0d got %h/%h/%h exp %h/%h/%h", n, if_valid, if_instr, if_pc, m_valid, m_instr, m_ifpc); end
      checks++; if (dbg_rvalid !== m_rvalid || dbg_rdata !== m_rdata) begin errors++; $display("FAIL rnd_dbg n=%0d got %h/%h exp %h/%h", n, dbg_rvalid, dbg_rdata, m_rvalid, m_rdata); end
    end
    dbg_req = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0] = 32'hE3A00015;
    imem[1] = 32'hE3A01A01;
    imem[2] = 32'hE3A0DC02;
    imem[7] = 32'hEAFFFFFF;
    test_reset();
    test_fetch();
    test_freeze();
    test_branch();
    test_debug_starvation();
    test_debug_freeze();
    test_wrap();
    test_reset_after_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
